// File: rtl/bhg_line_fetch_pkg.sv
// Shared constants and FSM state type for the scanline fetcher.
package bhg_line_fetch_pkg;

  localparam int WORD_BYTES   = 16;
  localparam int PIX_PER_WORD = 4;
  localparam int TAG_W        = 10;
  localparam int IDX_W        = TAG_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/bhg_line_fetch_addr.sv
// Registered DDR3 read address generator: line base accumulates one stride per
// scanline, the word address steps by one 128-bit word per accepted request.
module bhg_line_fetch_addr
  import bhg_line_fetch_pkg::*;
#(
  parameter int ADDR_W      = 29,
  parameter int LINE_STRIDE = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              next_line,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] STRIDE_V = ADDR_W'(LINE_STRIDE);
  localparam logic [ADDR_W-1:0] WORD_V   = ADDR_W'(WORD_BYTES);

  logic [ADDR_W-1:0] line_base_q;
  logic [ADDR_W-1:0] addr_q;

  // Sums wrap modulo 2^ADDR_W by construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_base_q <= '0;
      addr_q      <= '0;
    end else if (load) begin
      line_base_q <= base;
      addr_q      <= base;
    end else if (next_line) begin
      line_base_q <= line_base_q + STRIDE_V;
      addr_q      <= line_base_q + STRIDE_V;
    end else if (advance) begin
      addr_q      <= addr_q + WORD_V;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/bhg_line_fetch.sv
// Scanline fetcher feeding the dual-line buffer of the video pattern generator.
// Optional saturating underrun counter enabled by BHG_LINE_FETCH_STATS_EN.
module bhg_line_fetch
  import bhg_line_fetch_pkg::*;
#(
  parameter int ADDR_W         = 29,
  parameter int WORDS_PER_LINE = 180,
  parameter int LINE_STRIDE    = 4096,
  parameter int V_LINES        = 480
) (
  input  logic              CMD_CLK,
  input  logic              RESET,
  input  logic              CMD_xena_in,
  input  logic              CMD_yena_in,
  input  logic [ADDR_W-1:0] frame_base,
  output logic [1:0]        CMD_xpos_out,
  output logic              CMD_ypos_out,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [TAG_W-1:0]  rd_vector,
  input  logic              rd_busy,
  input  logic              rd_ready,
  input  logic [127:0]      rd_data,
  input  logic [TAG_W-1:0]  rd_vector_ret,
  output logic              CMD_line_mem_wena,
  output logic [TAG_W-1:0]  CMD_line_mem_waddr,
  output logic [127:0]      CMD_line_mem_wdata,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  localparam int LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  // Request handshake: a read is transferred on every cycle where rd_req=1 and
  // rd_busy=0; rd_addr/rd_vector are held stable while rd_busy stalls it.
  state_e             state_q, state_d;
  logic               xena_q, yena_q;
  logic               fe, le;
  logic [LINE_W-1:0]  line_q;
  logic [IDX_W-1:0]   issue_idx_q;
  logic [IDX_W:0]     rcv_cnt_q;
  logic               fetch_buf_q, ypos_q, pending_q;
  logic [1:0]         xpos_q;
  logic               underrun_q;
  logic               wena_q;
  logic [TAG_W-1:0]   waddr_q;
  logic [127:0]       wdata_q;
  logic               start_frame, start_line, swap, accept, underrun_set;
  logic               last_idx, line_has_next, ret_ok;

  assign fe = yena_q & ~CMD_yena_in;
  assign le = xena_q & ~CMD_xena_in & yena_q;

  assign last_idx      = (issue_idx_q == IDX_W'(WORDS_PER_LINE - 1));
  assign line_has_next = (({1'b0, line_q} + 1'b1) < (LINE_W + 1)'(V_LINES));
  assign ret_ok        = rd_ready & (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    start_frame  = 1'b0;
    start_line   = 1'b0;
    swap         = 1'b0;
    accept       = 1'b0;
    underrun_set = 1'b0;
    if (fe) begin
      start_frame = 1'b0 | 1'b1;
      state_d     = ISSUE;
    end else begin
      case (state_q)
        IDLE: begin
          // A deferred line event is serviced as soon as the fetch is done.
          if (le | pending_q) begin
            swap = 1'b1;
            if (line_has_next) begin
              start_line = 1'b1;
              state_d    = ISSUE;
            end
          end
        end
        ISSUE: begin
          accept = ~rd_busy;
          if (accept && last_idx) state_d = DRAIN;
          if (le) underrun_set = 1'b1;
        end
        DRAIN: begin
          if (rcv_cnt_q == (IDX_W + 1)'(WORDS_PER_LINE)) state_d = IDLE;
          if (le) underrun_set = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CMD_CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      xena_q      <= 1'b0;
      yena_q      <= 1'b0;
      line_q      <= '0;
      issue_idx_q <= '0;
      rcv_cnt_q   <= '0;
      fetch_buf_q <= 1'b0;
      ypos_q      <= 1'b0;
      xpos_q      <= 2'd0;
      pending_q   <= 1'b0;
      underrun_q  <= 1'b0;
      wena_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q    <= state_d;
      xena_q     <= CMD_xena_in;
      yena_q     <= CMD_yena_in;
      underrun_q <= underrun_set;
      wena_q     <= ret_ok;
      if (ret_ok) begin
        waddr_q <= rd_vector_ret;
        wdata_q <= rd_data;
      end
      if (start_frame) begin
        line_q      <= '0;
        fetch_buf_q <= ~ypos_q;
        xpos_q      <= frame_base[3:2];
        issue_idx_q <= '0;
        rcv_cnt_q   <= '0;
        pending_q   <= 1'b0;
      end else begin
        if (swap) begin
          ypos_q    <= fetch_buf_q;
          pending_q <= 1'b0;
        end
        if (start_line) begin
          line_q      <= line_q + 1'b1;
          fetch_buf_q <= ~fetch_buf_q;
          issue_idx_q <= '0;
          rcv_cnt_q   <= '0;
        end
        if (accept && !last_idx) issue_idx_q <= issue_idx_q + 1'b1;
        if (underrun_set) pending_q <= 1'b1;
        if (ret_ok) rcv_cnt_q <= rcv_cnt_q + 1'b1;
      end
    end
  end

  bhg_line_fetch_addr #(
    .ADDR_W      (ADDR_W),
    .LINE_STRIDE (LINE_STRIDE)
  ) u_addr (
    .clk       (CMD_CLK),
    .reset     (RESET),
    .load      (start_frame),
    .next_line (start_line),
    .advance   (accept & ~last_idx),
    .base      ({frame_base[ADDR_W-1:4], 4'b0}),
    .addr      (rd_addr)
  );

`ifdef BHG_LINE_FETCH_STATS_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge CMD_CLK) begin
    if (RESET) begin
      ucnt_q <= 16'd0;
    end else if (start_frame && frame_base[0]) begin
      ucnt_q <= 16'd0;
    end else if (underrun_set && ucnt_q != 16'hFFFF) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end
  assign underrun_cnt = ucnt_q;
  logic unused_fb;
  assign unused_fb = frame_base[1];
`else
  assign underrun_cnt = 16'd0;
  logic unused_fb;
  assign unused_fb = ^frame_base[1:0];
`endif

  assign rd_req             = (state_q == ISSUE);
  assign rd_vector          = {fetch_buf_q, issue_idx_q};
  assign CMD_xpos_out       = xpos_q;
  assign CMD_ypos_out       = ypos_q;
  assign CMD_line_mem_wena  = wena_q;
  assign CMD_line_mem_waddr = waddr_q;
  assign CMD_line_mem_wdata = wdata_q;
  assign underrun           = underrun_q;

endmodule
